// File: rtl/skin_pkg.sv
// Skin-tone chroma transform constants and per-channel MEAN/GAIN tables.
// Tables are functions of luma Y (clipped to Y_MIN..Y_MAX); GAIN is Q2.8.
// Inside the pass band [K_L, K_H] the table values are unused by the pipe.
package skin_pkg;

  localparam int unsigned K_L       = 125;
  localparam int unsigned K_H       = 188;
  localparam int unsigned Y_MIN     = 16;
  localparam int unsigned Y_MAX     = 235;
  localparam int unsigned CENTER_CB = 108;
  localparam int unsigned CENTER_CR = 154;
  localparam int unsigned FRAC_W    = 8;

  // Clip luma into the nominal video range before table lookup.
  function automatic int unsigned y_clip(input int unsigned y);
    if (y < Y_MIN) return Y_MIN;
    if (y > Y_MAX) return Y_MAX;
    return y;
  endfunction

  // Mean chroma of the skin cluster as a function of Y.
  function automatic int unsigned mean_of(input int unsigned chan, input int unsigned y);
    int unsigned yc;
    yc = y_clip(y);
    if (chan == 0) begin
      if (yc < K_L) return 118 - ((yc - Y_MIN) >> 3);
      if (yc > K_H) return 108 + ((yc - K_H) >> 2);
      return CENTER_CB;
    end
    if (yc < K_L) return 150 + ((yc - Y_MIN) >> 4);
    if (yc > K_H) return 154 - ((yc - K_H) >> 3);
    return CENTER_CR;
  endfunction

  // Spread-compensation gain (Q2.8) as a function of Y.
  function automatic int unsigned gain_of(input int unsigned chan, input int unsigned y);
    int unsigned yc;
    yc = y_clip(y);
    if (chan == 0) begin
      if (yc < K_L) return 523 - ((yc - Y_MIN) >> 1);
      if (yc > K_H) return 400;
      return 256;
    end
    if (yc < K_L) return 480 - ((yc - Y_MIN) >> 2);
    if (yc > K_H) return 360;
    return 256;
  endfunction

endpackage

// File: rtl/chroma_lut.sv
// Combinational MEAN/GAIN lookup for one chroma channel.
// Params: DATA_W, GAIN_W, CHAN (0 = Cb, 1 = Cr)
// Ports : y (luma) -> mean (DATA_W), gain (GAIN_W, Q2.8)
module chroma_lut
  import skin_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAIN_W = 10,
  parameter int unsigned CHAN   = 0
) (
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] mean,
  output logic [GAIN_W-1:0] gain
);

  always_comb begin
    mean = DATA_W'(mean_of(CHAN, 32'(y)));
    gain = GAIN_W'(gain_of(CHAN, 32'(y)));
  end

endmodule

// File: rtl/chroma_trans_pipe.sv
// 5-stage skin-tone chroma transform: S0 reg, S1 LUT, S2 subtract,
// S3 multiply, S4 shift/add/clamp. Valid/ready with global stall.
// Ports: clk, rst_n (async, active-low), in_valid/in_ready, y_in, c_in,
//        out_valid/out_ready, c_out.
// Macro CHROMA_SAT_EN: saturate the final sum to 0..2^DATA_W-1;
// undefined, the sum wraps to its low DATA_W bits.
module chroma_trans_pipe
  import skin_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAIN_W = 10,
  parameter int unsigned CHAN   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c_out
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam int unsigned CENTER = (CHAN == 0) ? CENTER_CB : CENTER_CR;
  localparam logic signed [PROD_W-1:0] CENTER_S = PROD_W'(CENTER);
`ifdef CHROMA_SAT_EN
  localparam logic signed [PROD_W-1:0] MAX_S = PROD_W'((1 << DATA_W) - 1);
`endif

  logic adv;
  logic v0, v1, v2, v3;

  logic [DATA_W-1:0] y0, c0, c1, c2, c3, mean1;
  logic [GAIN_W-1:0] gain1, gain2;
  logic              pass1, pass2, pass3;
  logic signed [DATA_W:0]   diff2;
  logic signed [PROD_W-1:0] prod3;

  logic [DATA_W-1:0]        lut_mean;
  logic [GAIN_W-1:0]        lut_gain;
  logic                     pass_c;
  logic signed [DATA_W:0]   diff_c;
  logic signed [PROD_W-1:0] diff_x, gain_x, prod_c, shifted_c, sum_c;
  logic [DATA_W-1:0]        result_c;

  // Whole pipe advances together whenever the output slot can move.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  chroma_lut #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .CHAN(CHAN)) u_lut (
    .y    (y0),
    .mean (lut_mean),
    .gain (lut_gain)
  );

  // Stage datapath arithmetic.
  always_comb begin
    pass_c    = (y0 >= DATA_W'(K_L)) && (y0 <= DATA_W'(K_H));
    diff_c    = $signed({1'b0, c1}) - $signed({1'b0, mean1});
    diff_x    = PROD_W'(diff2);
    gain_x    = PROD_W'({1'b0, gain2});
    prod_c    = diff_x * gain_x;
    shifted_c = prod3 >>> FRAC_W;
    sum_c     = shifted_c + CENTER_S;
`ifdef CHROMA_SAT_EN
    if (sum_c[PROD_W-1])    result_c = '0;
    else if (sum_c > MAX_S) result_c = '1;
    else                    result_c = DATA_W'(sum_c);
`else
    result_c = DATA_W'(sum_c);
`endif
  end

  // Valid chain and output register; cleared by reset so in-flight pixels vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      c_out     <= '0;
    end else if (adv) begin
      v0        <= in_valid;
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      c_out     <= pass3 ? c3 : result_c;
    end
  end

  // Data stages carry no reset; their validity is tracked by the chain above.
  always_ff @(posedge clk) begin
    if (adv) begin
      y0    <= y_in;
      c0    <= c_in;
      c1    <= c0;
      mean1 <= lut_mean;
      gain1 <= lut_gain;
      pass1 <= pass_c;
      c2    <= c1;
      diff2 <= diff_c;
      gain2 <= gain1;
      pass2 <= pass1;
      c3    <= c2;
      prod3 <= prod_c;
      pass3 <= pass2;
    end
  end

endmodule

// File: tb/tb_chroma_trans_pipe.sv
// Directed bench for chroma_trans_pipe (CHAN = 0, DATA_W = 8).
module tb_chroma_trans_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y_in;
  logic [7:0] c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] c_out;

  int checks = 0;
  int errors = 0;

  chroma_trans_pipe #(.DATA_W(8), .GAIN_W(10), .CHAN(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [7:0] c;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    int         rx;
    int         tx;
    int         stall_left;
    bit         stall_done;
    logic [7:0] held;
    bit         iv[20];
    int         seen;

    vecs[0] = '{y: 8'd150, c: 8'd77,  exp: 8'd77};
    vecs[1] = '{y: 8'd16,  c: 8'd118, exp: 8'd108};
    vecs[2] = '{y: 8'd16,  c: 8'd100, exp: 8'd71};
`ifdef CHROMA_SAT_EN
    vecs[3] = '{y: 8'd16,  c: 8'd200, exp: 8'd255};
`else
    vecs[3] = '{y: 8'd16,  c: 8'd200, exp: 8'd19};
`endif
    vecs[4] = '{y: 8'd125, c: 8'd3,   exp: 8'd3};
    vecs[5] = '{y: 8'd188, c: 8'd250, exp: 8'd250};
    vecs[6] = '{y: 8'd124, c: 8'd105, exp: 8'd108};
    vecs[7] = '{y: 8'd189, c: 8'd118, exp: 8'd123};

    rst_n = 1'b0; in_valid = 1'b0; y_in = '0; c_in = '0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_c_out", int'(c_out), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // Single pixels: value and latency.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; y_in = vecs[i].y; c_in = vecs[i].c;
      n = 0;
      for (int k = 1; k <= 12; k++) begin
        step();
        in_valid = 1'b0;
        if (out_valid) begin n = k; break; end
      end
      if (n == 0) check($sformatf("vec%0d_timeout", i), 0, 1);
      else begin
        check($sformatf("vec%0d_latency", i), n, 5);
        check($sformatf("vec%0d_c_out", i), int'(c_out), int'(vecs[i].exp));
      end
      step(); step();
    end

    // Back-to-back stream of 10 with a 3-cycle output stall at the 4th result.
    rx = 0; tx = 0; stall_left = 0; stall_done = 1'b0; held = '0;
    for (int cyc = 0; cyc < 100 && rx < 10; cyc++) begin
      if (out_valid && rx == 3 && !stall_done) begin
        stall_left = 3; stall_done = 1'b1; held = c_out;
      end
      out_ready = (stall_left == 0);
      in_valid  = (tx < 10);
      y_in      = 8'd150;
      c_in      = 8'(10 + tx);
      #1;
      if (stall_left > 0) begin
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_c_hold", int'(c_out), int'(held));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream_%0d", rx), int'(c_out), 10 + rx);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", rx, 10);
    check("stall_seen", int'(stall_done), 1);
    step(); step();
    check("stream_drained", int'(out_valid), 0);

    // Reset with pixels in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; y_in = 8'd16; c_in = 8'd200;
      step();
    end
    in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 10 && !out_valid; k++) begin step(); n++; end
    check("rst_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_c_out", int'(c_out), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; y_in = 8'd150; c_in = 8'd55;
    n = 0; seen = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      in_valid = 1'b0;
      if (out_valid) begin
        seen++;
        if (n == 0) n = k;
        check("rst_post_c_out", int'(c_out), 55);
      end
    end
    check("rst_post_latency", n, 5);
    check("rst_post_count", seen, 1);

    // Alternating in_valid at full rate.
    for (int i = 0; i < 20; i++) begin
      if (i >= 5) begin
        check($sformatf("alt_valid_%0d", i), int'(out_valid), int'(iv[i-5]));
        if (iv[i-5]) check($sformatf("alt_c_%0d", i), int'(c_out), i - 5);
      end else begin
        check($sformatf("alt_valid_%0d", i), int'(out_valid), 0);
      end
      iv[i]    = (i < 12) && (i % 2 == 0);
      in_valid = iv[i];
      y_in     = 8'd130;
      c_in     = 8'(i);
      step();
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chroma_trans_pipe.md
CHROMA_TRANS_PIPE -- requirements
Module: chroma_trans_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel component width, unsigned.
REQ-002 SHALL have parameter GAIN_W, default 10: gain LUT width, unsigned Q2.8.
REQ-003 SHALL have parameter CHAN, default 0: chroma channel, 0 = Cb, 1 = Cr; selects the LUT tables and CENTER.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  input pixel present.
REQ-007 in_ready  out  1  block accepts the input pixel this cycle.
REQ-008 y_in  in  DATA_W  luma.
REQ-009 c_in  in  DATA_W  chroma, Cb or Cr per CHAN.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 c_out  out  DATA_W  transformed chroma.

Function
REQ-013 SHALL be a 5-stage pipeline: S0 register, S1 LUT, S2 subtract, S3 multiply, S4 add/clamp; c_out is registered at S4.
- Latency SHALL be exactly 5 clk edges from the input handshake to out_valid while there is no stall.
REQ-014 A transfer SHALL occur on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-015 Stall rule SHALL be: adv = !out_valid || out_ready; in_ready = adv; all stage registers and stage valid bits update only when adv = 1.
- While stalled, c_out and out_valid SHALL hold stable.
REQ-016 Stage valid bits SHALL propagate without gaps; bubbles (in_valid = 0) SHALL be carried through as valid = 0.
REQ-017 Pass band: if K_L <= Y <= K_H, with the comparison made on the S0-registered Y, c_out SHALL equal c_in unchanged.
REQ-018 Outside the pass band, c_out SHALL equal clamp(((c - MEAN[Y]) * GAIN[Y]) >>> 8 + CENTER).
- The subtract is signed, DATA_W+1 bits.
- The product is signed, DATA_W+GAIN_W+1 bits.
- The shift is an arithmetic right shift (floor).
- The add is signed, with headroom of at least 2 bits.
REQ-019 MEAN and GAIN SHALL be read in S1 from the package tables for the selected CHAN, indexed by the S0-registered Y.
REQ-020 A simultaneous input and output handshake SHALL be sustained at 1 pixel per clock with no bubble inserted.

Reset
REQ-021 While rst_n = 0, all stage valid bits, out_valid and c_out SHALL be 0; in_ready SHALL be 1.
REQ-022 Asserting rst_n in mid-stream SHALL discard every in-flight pixel, with no partial output.
- The first valid result after reset SHALL be for the first pixel accepted after deassertion.
REQ-023 Data registers other than c_out are not required to be reset.

Configuration
REQ-024 Macro CHROMA_SAT_EN defined:
- A final sum below 0 SHALL give c_out = 0.
- A final sum above 2^DATA_W-1 SHALL give c_out = 2^DATA_W-1.
REQ-025 Macro CHROMA_SAT_EN undefined: c_out SHALL be the low DATA_W bits of the sum (wrap-around), and the clamp logic SHALL be absent.

Structure
REQ-026 Package skin_pkg SHALL hold:
- K_L = 125, K_H = 188, Y_MIN = 16, Y_MAX = 235;
- CENTER_CB = 108, CENTER_CR = 154;
- the MEAN and GAIN tables per channel, as functions of Y.
REQ-027 Sub-module chroma_lut (inputs CHAN, Y; outputs MEAN, GAIN), purely combinational, SHALL be instantiated once, ahead of the S1 registers.
REQ-028 Package values SHALL include, for Cb, MEAN[16] = 118 and GAIN[16] = 523.

Verification
REQ-029 The bench SHALL cover these directed scenarios (CHAN = 0, DATA_W = 8):
- Y = 150, Cb = 77, out_ready = 1 -> c_out = 77, out_valid high exactly 5 cycles after acceptance.
- Y = 16, Cb = 118 -> c_out = 108. Y = 16, Cb = 100 -> c_out = 71, which checks the floor shift: -9414 >>> 8 = -37.
- Y = 16, Cb = 200 -> c_out = 255 with CHROMA_SAT_EN, and c_out = 19 without it.
- Stream 10 back-to-back pixels; hold out_ready = 0 for 3 cycles at the 4th output:
  - in_ready SHALL fall in the same cycle;
  - c_out SHALL hold;
  - all 10 results SHALL appear in order with none lost or duplicated.
- Pulse rst_n low for 1 cycle with 3 pixels in flight:
  - outputs SHALL go to 0 immediately;
  - no in-flight result SHALL ever appear;
  - the next accepted pixel SHALL emerge 5 cycles later.
- Alternate in_valid 1/0 at full rate with out_ready = 1 -> out_valid SHALL alternate the same way, delayed by 5 cycles.
